// File: rtl/traffic_pkg.sv
// Shared constants for the intersection conflict monitor: colour encodings,
// reconstructed phase codes and fault cause codes.
package traffic_pkg;

  localparam logic [2:0] RED    = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b100;

  localparam logic [2:0] PH_B_GREEN  = 3'd0;
  localparam logic [2:0] PH_B_YELLOW = 3'd1;
  localparam logic [2:0] PH_ALLRED_B = 3'd2;
  localparam logic [2:0] PH_A_GREEN  = 3'd3;
  localparam logic [2:0] PH_A_YELLOW = 3'd4;
  localparam logic [2:0] PH_ALLRED_A = 3'd5;
  localparam logic [2:0] PH_UNKNOWN  = 3'd7;

  localparam logic [2:0] F_NONE        = 3'd0;
  localparam logic [2:0] F_ENCODING    = 3'd1;
  localparam logic [2:0] F_CONFLICT    = 3'd2;
  localparam logic [2:0] F_ILLEGAL     = 3'd3;
  localparam logic [2:0] F_SHORT_GREEN = 3'd4;
  localparam logic [2:0] F_YELLOW      = 3'd5;
  localparam logic [2:0] F_ALLRED      = 3'd6;
  localparam logic [2:0] F_STALL       = 3'd7;

  function automatic logic is_colour(input logic [2:0] c);
    return (c == RED) || (c == YELLOW) || (c == GREEN);
  endfunction

endpackage

// File: rtl/light_seq_checker.sv
// Per-light colour tracker: remembers the last valid colour and how long it
// has been held, and flags illegal steps and dwell violations on this sample.
module light_seq_checker
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 6,
  parameter int YELLOW_MIN = 1,
  parameter int YELLOW_MAX = 2,
  parameter int CW         = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       check,
  input  logic [2:0] colour,
  output logic       changed,
  output logic       illegal,
  output logic       short_green,
  output logic       yellow_bad,
  output logic       left_red
);

  localparam logic [CW-1:0] MIN_GREEN_C  = CW'(MIN_GREEN);
  localparam logic [CW-1:0] YELLOW_MIN_C = CW'(YELLOW_MIN);
  localparam logic [CW-1:0] YELLOW_MAX_C = CW'(YELLOW_MAX);
  localparam logic [CW-1:0] CNT_MAX      = '1;

  logic [2:0]    prev;
  logic [CW-1:0] dwell;
  logic [CW-1:0] dwell_next;
  logic          legal_step;

  assign changed    = check && (colour != prev);
  assign legal_step = ((prev == RED)    && (colour == GREEN))  ||
                      ((prev == GREEN)  && (colour == YELLOW)) ||
                      ((prev == YELLOW) && (colour == RED));

  // The baseline sample (check low) only loads the tracker.
  assign dwell_next = (changed || !check) ? CW'(1)
                    : ((dwell == CNT_MAX) ? dwell : dwell + CW'(1));

  assign illegal     = changed && !legal_step;
  assign short_green = changed && (prev == GREEN) && (dwell < MIN_GREEN_C);
  assign yellow_bad  = check &&
                       ((changed && (prev == YELLOW) && (dwell < YELLOW_MIN_C)) ||
                        (!changed && (colour == YELLOW) && (dwell_next > YELLOW_MAX_C)));
  assign left_red    = changed && (prev == RED);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= RED;
      dwell <= '0;
    end else if (en) begin
      prev  <= colour;
      dwell <= dwell_next;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive monitor beside the two-approach controller: reconstructs the phase,
// checks the light sequence and latches the first fault cause until reset.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 6,
  parameter int YELLOW_MIN = 1,
  parameter int YELLOW_MAX = 2,
  parameter int ALLRED_MIN = 1,
  parameter int STALL_MAX  = 15,
  parameter int CW         = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_A,
  input  logic [2:0] light_B,
  output logic [2:0] phase,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       fault_pulse,
  output logic [7:0] cycles_done
);

  localparam logic [CW-1:0] ALLRED_MIN_C = CW'(ALLRED_MIN);
  localparam logic [CW-1:0] STALL_MAX_C  = CW'(STALL_MAX);
  localparam logic [CW-1:0] CNT_MAX      = '1;

  logic          valid, have_base, check;
  logic          a_red, b_red, all_red, conflict;
  logic          a_changed, a_illegal, a_short, a_yellow, a_left_red;
  logic          b_changed, b_illegal, b_short, b_yellow, b_left_red;
  logic [CW-1:0] allred_cnt, allred_next;
  logic [CW-1:0] stall_cnt, stall_next;
  logic          allred_bad, stall_bad;
  logic [2:0]    phase_next;
  logic [2:0]    cause;

  assign valid    = is_colour(light_A) && is_colour(light_B);
  assign check    = valid && have_base;
  assign a_red    = (light_A == RED);
  assign b_red    = (light_B == RED);
  assign all_red  = a_red && b_red;
  assign conflict = valid && !a_red && !b_red;

  light_seq_checker #(
    .MIN_GREEN (MIN_GREEN),
    .YELLOW_MIN(YELLOW_MIN),
    .YELLOW_MAX(YELLOW_MAX),
    .CW        (CW)
  ) u_chk_a (
    .clk        (clk),
    .rst        (rst),
    .en         (valid),
    .check      (check),
    .colour     (light_A),
    .changed    (a_changed),
    .illegal    (a_illegal),
    .short_green(a_short),
    .yellow_bad (a_yellow),
    .left_red   (a_left_red)
  );

  light_seq_checker #(
    .MIN_GREEN (MIN_GREEN),
    .YELLOW_MIN(YELLOW_MIN),
    .YELLOW_MAX(YELLOW_MAX),
    .CW        (CW)
  ) u_chk_b (
    .clk        (clk),
    .rst        (rst),
    .en         (valid),
    .check      (check),
    .colour     (light_B),
    .changed    (b_changed),
    .illegal    (b_illegal),
    .short_green(b_short),
    .yellow_bad (b_yellow),
    .left_red   (b_left_red)
  );

  // The stall count includes the sample on which the last change happened.
  assign stall_next  = (a_changed || b_changed) ? CW'(1)
                     : ((stall_cnt == CNT_MAX) ? stall_cnt : stall_cnt + CW'(1));
  assign allred_next = !all_red ? '0
                     : ((allred_cnt == CNT_MAX) ? allred_cnt : allred_cnt + CW'(1));

  assign stall_bad  = check && (stall_next > STALL_MAX_C);
  assign allred_bad = (a_left_red || b_left_red) && (allred_cnt < ALLRED_MIN_C);

  always_comb begin
    cause = F_NONE;
    if (!valid)                        cause = F_ENCODING;
    else if (conflict)                 cause = F_CONFLICT;
    else if (a_illegal || b_illegal)   cause = F_ILLEGAL;
    else if (a_short || b_short)       cause = F_SHORT_GREEN;
    else if (a_yellow || b_yellow)     cause = F_YELLOW;
    else if (allred_bad)               cause = F_ALLRED;
    else if (stall_bad)                cause = F_STALL;
  end

  // All-red is attributed to whichever approach last showed a non-red colour.
  always_comb begin
    phase_next = phase;
    if (valid) begin
      if (conflict) begin
        phase_next = PH_UNKNOWN;
      end else if (all_red) begin
        case (phase)
          PH_B_GREEN, PH_B_YELLOW, PH_ALLRED_B: phase_next = PH_ALLRED_B;
          PH_A_GREEN, PH_A_YELLOW, PH_ALLRED_A: phase_next = PH_ALLRED_A;
          default:                              phase_next = PH_UNKNOWN;
        endcase
      end else if (!a_red) begin
        phase_next = (light_A == GREEN) ? PH_A_GREEN : PH_A_YELLOW;
      end else begin
        phase_next = (light_B == GREEN) ? PH_B_GREEN : PH_B_YELLOW;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      have_base   <= 1'b0;
      allred_cnt  <= '0;
      stall_cnt   <= '0;
      phase       <= PH_UNKNOWN;
      fault       <= 1'b0;
      fault_code  <= F_NONE;
      fault_pulse <= 1'b0;
      cycles_done <= '0;
    end else begin
      fault_pulse <= 1'b0;
      if (!fault && (cause != F_NONE)) begin
        fault       <= 1'b1;
        fault_code  <= cause;
        fault_pulse <= 1'b1;
      end
      if (valid) begin
        have_base  <= 1'b1;
        allred_cnt <= allred_next;
        stall_cnt  <= stall_next;
      end
      phase <= phase_next;
      if ((phase == PH_ALLRED_A) && (phase_next == PH_B_GREEN))
        cycles_done <= cycles_done + 8'd1;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: a history-based reference model
// is compared against every output on each cycle, plus literal spot checks.
module tb_traffic_light_monitor;

  localparam int MIN_GREEN  = 6;
  localparam int YELLOW_MIN = 1;
  localparam int YELLOW_MAX = 2;
  localparam int ALLRED_MIN = 1;
  localparam int STALL_MAX  = 15;

  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b100;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] light_a = R;
  logic [2:0] light_b = R;
  logic [2:0] phase;
  logic       fault;
  logic [2:0] fault_code;
  logic       fault_pulse;
  logic [7:0] cycles_done;

  always #5 clk = ~clk;

  traffic_light_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .light_A    (light_a),
    .light_B    (light_b),
    .phase      (phase),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_pulse(fault_pulse),
    .cycles_done(cycles_done)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // reference model: history of valid samples {A,B} since reset
  logic [5:0] hist[$];
  logic [2:0] exp_phase  = 3'd7;
  logic       exp_fault  = 1'b0;
  logic [2:0] exp_code   = 3'd0;
  logic       exp_pulse  = 1'b0;
  logic [7:0] exp_cycles = 8'd0;

  function automatic bit is_col(input logic [2:0] c);
    return (c == R) || (c == Y) || (c == G);
  endfunction

  function automatic logic [2:0] colour_of(input logic [5:0] e, input int l);
    return (l == 0) ? e[5:3] : e[2:0];
  endfunction

  function automatic bit legal_step(input logic [2:0] p, input logic [2:0] c);
    return ((p == R) && (c == G)) || ((p == G) && (c == Y)) || ((p == Y) && (c == R));
  endfunction

  function automatic int trail_light(input int l, input logic [2:0] col);
    int n;
    n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (colour_of(hist[i], l) != col) break;
      n++;
    end
    return n;
  endfunction

  function automatic int trail_pair(input logic [5:0] v);
    int n;
    n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != v) break;
      n++;
    end
    return n;
  endfunction

  function automatic logic [2:0] allred_phase();
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != {R, R}) begin
        if (hist[i][5:3] != R && hist[i][2:0] != R) return 3'd7;
        return (hist[i][2:0] != R) ? 3'd2 : 3'd5;
      end
    end
    return 3'd7;
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_phase  = 3'd7;
    exp_fault  = 1'b0;
    exp_code   = 3'd0;
    exp_pulse  = 1'b0;
    exp_cycles = 8'd0;
  endtask

  task automatic model_step(input logic [2:0] a, input logic [2:0] b);
    int         cause;
    logic [5:0] prev;
    logic [5:0] cur;
    logic [2:0] p, c, old_phase;
    int         d;
    bit         ill, shortg, yel, leftr;
    cause  = 0;
    cur    = {a, b};
    ill    = 0;
    shortg = 0;
    yel    = 0;
    leftr  = 0;
    if (!is_col(a) || !is_col(b)) begin
      cause = 1;
    end else begin
      if (a != R && b != R) begin
        cause = 2;
      end else if (hist.size() > 0) begin
        prev = hist[hist.size() - 1];
        for (int l = 0; l < 2; l++) begin
          p = colour_of(prev, l);
          c = colour_of(cur, l);
          d = trail_light(l, p);
          if (p != c && !legal_step(p, c))                 ill = 1;
          if (p == G && c != G && d < MIN_GREEN)           shortg = 1;
          if (p == Y && c != Y && d < YELLOW_MIN)          yel = 1;
          if (p == Y && c == Y && d + 1 > YELLOW_MAX)      yel = 1;
          if (p == R && c != R)                            leftr = 1;
        end
        if (ill)                                               cause = 3;
        else if (shortg)                                       cause = 4;
        else if (yel)                                          cause = 5;
        else if (leftr && trail_pair({R, R}) < ALLRED_MIN)     cause = 6;
        else if (cur == prev && trail_pair(prev) + 1 > STALL_MAX) cause = 7;
      end
      old_phase = exp_phase;
      if (a != R && b != R)      exp_phase = 3'd7;
      else if (a == R && b == R) exp_phase = allred_phase();
      else if (a == G)           exp_phase = 3'd3;
      else if (a == Y)           exp_phase = 3'd4;
      else if (b == G)           exp_phase = 3'd0;
      else                       exp_phase = 3'd1;
      if (old_phase == 3'd5 && exp_phase == 3'd0) exp_cycles = exp_cycles + 8'd1;
      hist.push_back(cur);
    end
    if (!exp_fault && cause != 0) begin
      exp_fault = 1'b1;
      exp_code  = 3'(cause);
      exp_pulse = 1'b1;
    end else begin
      exp_pulse = 1'b0;
    end
  endtask

  // scoreboard
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_lit(input string name, input logic [7:0] got,
                           input logic [7:0] mdl, input logic [7:0] lit);
    check({name, "_dut"}, got, lit);
    check({name, "_model"}, mdl, lit);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("phase", 8'(phase), 8'(exp_phase));
      check("fault", 8'(fault), 8'(exp_fault));
      check("fault_code", 8'(fault_code), 8'(exp_code));
      check("fault_pulse", 8'(fault_pulse), 8'(exp_pulse));
      check("cycles_done", cycles_done, exp_cycles);
    end
  end

  // driver tasks: each returns at a falling edge
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input logic [2:0] a, input logic [2:0] b);
    light_a = a;
    light_b = b;
    @(posedge clk);
    model_step(a, b);
    @(negedge clk);
  endtask

  task automatic run(input logic [2:0] a, input logic [2:0] b, input int n);
    for (int i = 0; i < n; i++) step(a, b);
  endtask

  task automatic full_cycle();
    run(R, G, 6); run(R, Y, 1); run(R, R, 1);
    run(G, R, 6); run(Y, R, 1); run(R, R, 1);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    cmp_en = 1'b1;
    check_lit("reset_phase", 8'(phase), 8'(exp_phase), 8'd7);
    check_lit("reset_fault", 8'(fault), 8'(exp_fault), 8'd0);

    // legal sequence, three full cycles
    for (int k = 0; k < 3; k++) begin
      step(R, G);
      check_lit("legal_cycles", cycles_done, exp_cycles, 8'(k));
      run(R, G, 5); check_lit("legal_ph0", 8'(phase), 8'(exp_phase), 8'd0);
      run(R, Y, 1); check_lit("legal_ph1", 8'(phase), 8'(exp_phase), 8'd1);
      run(R, R, 1); check_lit("legal_ph2", 8'(phase), 8'(exp_phase), 8'd2);
      run(G, R, 6); check_lit("legal_ph3", 8'(phase), 8'(exp_phase), 8'd3);
      run(Y, R, 1); check_lit("legal_ph4", 8'(phase), 8'(exp_phase), 8'd4);
      run(R, R, 1); check_lit("legal_ph5", 8'(phase), 8'(exp_phase), 8'd5);
    end
    check_lit("legal_fault", 8'(fault), 8'(exp_fault), 8'd0);
    step(R, G);
    check_lit("legal_cycles_end", cycles_done, exp_cycles, 8'd3);

    // conflict
    do_reset();
    run(R, G, 3);
    step(G, G);
    check_lit("conflict_code", 8'(fault_code), 8'(exp_code), 8'd2);
    check_lit("conflict_pulse", 8'(fault_pulse), 8'(exp_pulse), 8'd1);
    step(R, G);
    check_lit("conflict_pulse_drop", 8'(fault_pulse), 8'(exp_pulse), 8'd0);
    check_lit("conflict_sticky", 8'(fault), 8'(exp_fault), 8'd1);

    // green -> red after 3 samples: illegal outranks short green
    do_reset();
    run(R, R, 1); run(G, R, 3);
    check_lit("short_pre", 8'(fault), 8'(exp_fault), 8'd0);
    step(R, R);
    check_lit("illegal_code", 8'(fault_code), 8'(exp_code), 8'd3);

    // green -> yellow after 3 samples: short green
    do_reset();
    run(R, R, 1); run(G, R, 3); step(Y, R);
    check_lit("short_code", 8'(fault_code), 8'(exp_code), 8'd4);

    // encoding fault, then a later conflict leaves the code alone
    do_reset();
    run(R, G, 6); run(R, Y, 1);
    step(R, 3'b011);
    check_lit("enc_code", 8'(fault_code), 8'(exp_code), 8'd1);
    check_lit("enc_phase_hold", 8'(phase), 8'(exp_phase), 8'd1);
    step(R, R);
    check_lit("enc_phase_allred", 8'(phase), 8'(exp_phase), 8'd2);
    step(G, G);
    check_lit("enc_code_kept", 8'(fault_code), 8'(exp_code), 8'd1);
    check_lit("enc_phase_conflict", 8'(phase), 8'(exp_phase), 8'd7);

    // stall: 16 unchanged samples fault, 15 then a change do not
    do_reset();
    run(R, G, 15);
    check_lit("stall_15", 8'(fault), 8'(exp_fault), 8'd0);
    step(R, G);
    check_lit("stall_code", 8'(fault_code), 8'(exp_code), 8'd7);
    do_reset();
    run(R, G, 15); run(R, Y, 1); run(R, R, 1);
    check_lit("stall_none", 8'(fault), 8'(exp_fault), 8'd0);

    // yellow held past its maximum
    do_reset();
    run(R, G, 6); run(R, Y, 3);
    check_lit("yellow_long", 8'(fault_code), 8'(exp_code), 8'd5);

    // reset in the middle of phase 3
    do_reset();
    full_cycle();
    run(R, G, 6); run(R, Y, 1); run(R, R, 1); run(G, R, 2);
    check_lit("mid_phase", 8'(phase), 8'(exp_phase), 8'd3);
    check_lit("mid_cycles", cycles_done, exp_cycles, 8'd1);
    do_reset();
    check_lit("rst_phase", 8'(phase), 8'(exp_phase), 8'd7);
    check_lit("rst_cycles", cycles_done, exp_cycles, 8'd0);
    check_lit("rst_fault", 8'(fault), 8'(exp_fault), 8'd0);
    step(R, R);
    check_lit("rst_allred_phase", 8'(phase), 8'(exp_phase), 8'd7);
    check_lit("rst_allred_fault", 8'(fault), 8'(exp_fault), 8'd0);
    run(G, R, 6); run(Y, R, 1);
    check_lit("rst_resume_phase", 8'(phase), 8'(exp_phase), 8'd4);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
